// File: rtl/wb_write_queue.sv
// In-order write-back FIFO feeding the register file write port; entries appear one cycle after push and retire on rfReady.
// inReady depends on occupancy only (full blocks even with a same-cycle pop). Define WBQ_FORWARD_EN for youngest-match forwarding.
module wb_write_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [2:0]               inRegSel,
  input  logic [WIDTH-1:0]         inData,
  input  logic                     rfReady,
  output logic                     writeEn,
  output logic [2:0]               writeRegSel,
  output logic [WIDTH-1:0]         writeData,
  input  logic [2:0]               read1RegSel,
  input  logic [2:0]               read2RegSel,
  output logic                     read1Busy,
  output logic                     read2Busy,
  output logic [WIDTH-1:0]         read1Fwd,
  output logic [WIDTH-1:0]         read2Fwd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]       sel_mem [DEPTH];
  logic [WIDTH-1:0] dat_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic [PW-1:0]    age [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign inReady     = (count != CW'(DEPTH));
  assign writeEn     = (count != '0);
  assign push        = inValid & inReady;
  assign pop         = writeEn & rfReady;
  assign writeRegSel = writeEn ? sel_mem[head] : 3'd0;
  assign writeData   = writeEn ? dat_mem[head] : '0;
  assign err         = $isunknown({inValid, rfReady});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[tail] <= inRegSel;
      dat_mem[tail] <= inData;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i]    = PW'(i) - head;
      occ[i]    = ({1'b0, age[i]} < count);
      match1[i] = occ[i] && (sel_mem[i] == read1RegSel);
      match2[i] = occ[i] && (sel_mem[i] == read2RegSel);
    end
  end

  assign read1Busy = |match1;
  assign read2Busy = |match2;

`ifdef WBQ_FORWARD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin
    read1Fwd = '0;
    read2Fwd = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (match1[idx]) read1Fwd = dat_mem[idx];
      if (match2[idx]) read2Fwd = dat_mem[idx];
    end
  end
`else
  assign read1Fwd = '0;
  assign read2Fwd = '0;
`endif

endmodule
